// File: rtl/ov_pkg.sv
// Shared types and constants for the ov_capture camera pixel-capture front end.
package ov_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_VS = 2'd1,
        ACTIVE  = 2'd2
    } state_e;

    localparam int unsigned ERR_W    = 32'd3;
    localparam int unsigned ERR_PART = 32'd0;
    localparam int unsigned ERR_SAT  = 32'd1;
    localparam int unsigned ERR_HREF = 32'd2;

    // One-hot mask for a single stu_err flag.
    function automatic logic [ERR_W-1:0] err_mask(input int unsigned idx);
        err_mask = 3'b001 << idx;
    endfunction

endpackage

// File: rtl/ov_sync.sv
// Brings the DVP camera pins into clk_sys: 2-flop synchronisers, pclk/href edge
// detectors and a vsync debouncer that emits one-cycle rise/fall strobes.
module ov_sync
    import ov_pkg::*;
#(
    parameter int DW     = 8,
    parameter int VS_DEB = 8,
    parameter bit VS_POL = 1'b1
) (
    input  logic          clk_sys,
    input  logic          rst_n,
    input  logic          ov_vsync,
    input  logic          ov_href,
    input  logic          ov_pclk,
    input  logic [DW-1:0] ov_data,
    output logic          pclk_rise,
    output logic          href_s,
    output logic          href_fall,
    output logic [DW-1:0] data_s,
    output logic          vs_rise,
    output logic          vs_fall
);

    // Bit 0 is the first sync stage, bit 1 the second, bit 2 the edge-detect stage.
    logic [2:0]        pclk_sh_d, pclk_sh_q;
    logic [2:0]        href_sh_d, href_sh_q;
    logic [DW-1:0]     data_s1_d, data_s1_q;
    logic [DW-1:0]     data_s2_d, data_s2_q;
    logic [1:0]        vs_sh_d,   vs_sh_q;
    logic [VS_DEB-1:0] deb_sh_d,  deb_sh_q;
    logic              vs_deb_d,  vs_deb_q;
    logic              vs_act_s;
    logic              all_act_s;
    logic              all_inact_s;

    // The debouncer works on "active" rather than raw level so VS_POL only matters here.
    assign vs_act_s    = (vs_sh_q[1] == VS_POL);
    assign all_act_s   = &deb_sh_q;
    assign all_inact_s = ~|deb_sh_q;

    // Next-state for the synchroniser chains and debounce shift register.
    always_comb begin
        pclk_sh_d = {pclk_sh_q[1:0], ov_pclk};
        href_sh_d = {href_sh_q[1:0], ov_href};
        data_s1_d = ov_data;
        data_s2_d = data_s1_q;
        vs_sh_d   = {vs_sh_q[0], ov_vsync};
        deb_sh_d  = {deb_sh_q[VS_DEB-2:0], vs_act_s};
        if (all_act_s) begin
            vs_deb_d = 1'b1;
        end else if (all_inact_s) begin
            vs_deb_d = 1'b0;
        end else begin
            vs_deb_d = vs_deb_q;
        end
    end

    // Synchroniser and debounce state registers.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            pclk_sh_q <= 3'b000;
            href_sh_q <= 3'b000;
            data_s1_q <= '0;
            data_s2_q <= '0;
            vs_sh_q   <= {2{~VS_POL}};
            deb_sh_q  <= '0;
            vs_deb_q  <= 1'b0;
        end else begin
            pclk_sh_q <= pclk_sh_d;
            href_sh_q <= href_sh_d;
            data_s1_q <= data_s1_d;
            data_s2_q <= data_s2_d;
            vs_sh_q   <= vs_sh_d;
            deb_sh_q  <= deb_sh_d;
            vs_deb_q  <= vs_deb_d;
        end
    end

    assign pclk_rise = pclk_sh_q[1] & ~pclk_sh_q[2];
    assign href_s    = href_sh_q[1];
    assign href_fall = ~href_sh_q[1] & href_sh_q[2];
    assign data_s    = data_s2_q;
    assign vs_rise   = all_act_s & ~vs_deb_q;
    assign vs_fall   = all_inact_s & vs_deb_q;

endmodule

// File: rtl/ov_capture.sv
// Camera pixel-capture front end: frame FSM, beat-to-pixel assembly, line/frame
// counters and sticky error status for the register block.
module ov_capture
    import ov_pkg::*;
#(
    parameter int DW     = 8,
    parameter int BPP    = 2,
    parameter int VS_DEB = 8,
    parameter int CNT_W  = 16,
    parameter bit VS_POL = 1'b1
) (
    input  logic               clk_sys,
    input  logic               rst_n,
    input  logic               ov_vsync,
    input  logic               ov_href,
    input  logic               ov_pclk,
    input  logic [DW-1:0]      ov_data,
    input  logic               cfg_en,
    input  logic               cfg_clr,
    output logic               pix_valid,
    output logic [BPP*DW-1:0]  pix_data,
    output logic               pix_sof,
    output logic               pix_eol,
    output logic               pix_eof,
    output logic [CNT_W-1:0]   stu_line_len,
    output logic [CNT_W-1:0]   stu_line_cnt,
    output logic [CNT_W-1:0]   stu_frame_cnt,
    output logic [2:0]         stu_err,
    output logic               stu_busy
);

    localparam int              PW        = BPP * DW;
    localparam logic [1:0]      BEAT_LAST = 2'(BPP - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic          pclk_rise_s, href_s, href_fall_s, vs_rise_s, vs_fall_s;
    logic [DW-1:0] data_s;

    ov_sync #(
        .DW     (DW),
        .VS_DEB (VS_DEB),
        .VS_POL (VS_POL)
    ) u_sync (
        .clk_sys   (clk_sys),
        .rst_n     (rst_n),
        .ov_vsync  (ov_vsync),
        .ov_href   (ov_href),
        .ov_pclk   (ov_pclk),
        .ov_data   (ov_data),
        .pclk_rise (pclk_rise_s),
        .href_s    (href_s),
        .href_fall (href_fall_s),
        .data_s    (data_s),
        .vs_rise   (vs_rise_s),
        .vs_fall   (vs_fall_s)
    );

    state_e           state_d, state_q;
    logic             frame_start_s, frame_end_s;
    logic [1:0]       beat_idx_d, beat_idx_q;
    logic [PW-1:0]    asm_d, asm_q;
    logic [CNT_W-1:0] pix_cnt_d, pix_cnt_q;
    logic [CNT_W-1:0] line_cnt_d, line_cnt_q;
    logic             sof_pend_d, sof_pend_q;
    logic             pix_valid_d, pix_valid_q;
    logic [PW-1:0]    pix_data_d, pix_data_q;
    logic             pix_sof_d, pix_sof_q;
    logic             pix_eol_d, pix_eol_q;
    logic             pix_eof_d, pix_eof_q;
    logic [CNT_W-1:0] line_len_d, line_len_q;
    logic [CNT_W-1:0] frm_lines_d, frm_lines_q;
    logic [CNT_W-1:0] frame_cnt_d, frame_cnt_q;
    logic [2:0]       err_d, err_q;
    logic             busy_d, busy_q;

    logic             in_active_s, line_open_s, line_end_s, beat_s, pix_done_s;
    logic [PW-1:0]    asm_shift_s;
    logic [CNT_W-1:0] pix_cnt_inc_s, line_cnt_inc_s, lines_frame_s;
    logic [2:0]       err_set_s;

    // Frame FSM: next state plus frame start/end events.
    always_comb begin
        state_d       = state_q;
        frame_start_s = 1'b0;
        frame_end_s   = 1'b0;
        case (state_q)
            IDLE: begin
                state_d = cfg_en ? WAIT_VS : IDLE;
            end
            WAIT_VS: begin
                if (!cfg_en) begin
                    state_d = IDLE;
                end else if (vs_fall_s) begin
                    state_d       = ACTIVE;
                    frame_start_s = 1'b1;
                end else begin
                    state_d = WAIT_VS;
                end
            end
            ACTIVE: begin
                // cfg_en is only consulted at frame end so a frame is never truncated.
                if (vs_rise_s) begin
                    frame_end_s = 1'b1;
                    state_d     = cfg_en ? WAIT_VS : IDLE;
                end else begin
                    state_d = ACTIVE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // A line still open when vsync rises is closed first, so its partial pixel is flagged.
    assign in_active_s    = (state_q == ACTIVE);
    assign line_open_s    = (beat_idx_q != 2'd0) || (pix_cnt_q != '0);
    assign line_end_s     = in_active_s && (href_fall_s || (vs_rise_s && line_open_s));
    assign beat_s         = in_active_s && pclk_rise_s && href_s && !line_end_s;
    assign pix_done_s     = beat_s && (beat_idx_q == BEAT_LAST);
    assign asm_shift_s    = (asm_q << DW) | PW'(data_s);
    assign pix_cnt_inc_s  = (pix_cnt_q == CNT_MAX) ? pix_cnt_q : pix_cnt_q + CNT_ONE;
    assign line_cnt_inc_s = (line_cnt_q == CNT_MAX) ? line_cnt_q : line_cnt_q + CNT_ONE;
    assign lines_frame_s  = line_end_s ? line_cnt_inc_s : line_cnt_q;

    // Beat assembly and the running pixel/line counters.
    always_comb begin
        beat_idx_d = beat_idx_q;
        asm_d      = asm_q;
        pix_cnt_d  = pix_cnt_q;
        line_cnt_d = line_cnt_q;
        if (frame_start_s || line_end_s) begin
            beat_idx_d = 2'd0;
            asm_d      = '0;
            pix_cnt_d  = '0;
        end else if (beat_s) begin
            beat_idx_d = pix_done_s ? 2'd0 : beat_idx_q + 2'd1;
            asm_d      = asm_shift_s;
            pix_cnt_d  = pix_done_s ? pix_cnt_inc_s : pix_cnt_q;
        end else begin
            beat_idx_d = beat_idx_q;
        end
        if (frame_start_s || frame_end_s) begin
            line_cnt_d = '0;
        end else if (line_end_s) begin
            line_cnt_d = line_cnt_inc_s;
        end else begin
            line_cnt_d = line_cnt_q;
        end
    end

    // Output strobes, status registers and sticky error flags (set wins over clear).
    always_comb begin
        err_set_s = 3'b000;
        if (line_end_s && (beat_idx_q != 2'd0)) begin
            err_set_s = err_set_s | err_mask(ERR_PART);
        end else begin
            err_set_s = err_set_s;
        end
        if ((pix_done_s && (pix_cnt_q == CNT_MAX)) || (line_end_s && (line_cnt_q == CNT_MAX))) begin
            err_set_s = err_set_s | err_mask(ERR_SAT);
        end else begin
            err_set_s = err_set_s;
        end
        if (!in_active_s && href_s) begin
            err_set_s = err_set_s | err_mask(ERR_HREF);
        end else begin
            err_set_s = err_set_s;
        end

        if (frame_start_s) begin
            sof_pend_d = 1'b1;
        end else if (pix_done_s) begin
            sof_pend_d = 1'b0;
        end else begin
            sof_pend_d = sof_pend_q;
        end

        pix_valid_d = pix_done_s;
        pix_data_d  = pix_done_s ? asm_shift_s : pix_data_q;
        pix_sof_d   = pix_done_s && sof_pend_q;
        pix_eol_d   = line_end_s;
        pix_eof_d   = frame_end_s;
        line_len_d  = line_end_s ? pix_cnt_q : line_len_q;
        frm_lines_d = frame_end_s ? lines_frame_s : frm_lines_q;
        frame_cnt_d = (cfg_clr ? '0 : frame_cnt_q) + (frame_end_s ? CNT_ONE : '0);
        err_d       = (cfg_clr ? 3'b000 : err_q) | err_set_s;
        busy_d      = (state_d == ACTIVE);
    end

    // All state and registered outputs.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            beat_idx_q  <= 2'd0;
            asm_q       <= '0;
            pix_cnt_q   <= '0;
            line_cnt_q  <= '0;
            sof_pend_q  <= 1'b0;
            pix_valid_q <= 1'b0;
            pix_data_q  <= '0;
            pix_sof_q   <= 1'b0;
            pix_eol_q   <= 1'b0;
            pix_eof_q   <= 1'b0;
            line_len_q  <= '0;
            frm_lines_q <= '0;
            frame_cnt_q <= '0;
            err_q       <= 3'b000;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            beat_idx_q  <= beat_idx_d;
            asm_q       <= asm_d;
            pix_cnt_q   <= pix_cnt_d;
            line_cnt_q  <= line_cnt_d;
            sof_pend_q  <= sof_pend_d;
            pix_valid_q <= pix_valid_d;
            pix_data_q  <= pix_data_d;
            pix_sof_q   <= pix_sof_d;
            pix_eol_q   <= pix_eol_d;
            pix_eof_q   <= pix_eof_d;
            line_len_q  <= line_len_d;
            frm_lines_q <= frm_lines_d;
            frame_cnt_q <= frame_cnt_d;
            err_q       <= err_d;
            busy_q      <= busy_d;
        end
    end

    assign pix_valid     = pix_valid_q;
    assign pix_data      = pix_data_q;
    assign pix_sof       = pix_sof_q;
    assign pix_eol       = pix_eol_q;
    assign pix_eof       = pix_eof_q;
    assign stu_line_len  = line_len_q;
    assign stu_line_cnt  = frm_lines_q;
    assign stu_frame_cnt = frame_cnt_q;
    assign stu_err       = err_q;
    assign stu_busy      = busy_q;

endmodule

// File: tb/tb_ov_capture.sv
// Self-checking bench for ov_capture: table of frames plus hand-written corner
// sequences; expected pixels are queued when driven and popped when emitted.
module tb_ov_capture;

    localparam int DW     = 8;
    localparam int BPP    = 2;
    localparam int VS_DEB = 8;
    localparam int CNT_W  = 16;
    localparam int PW     = BPP * DW;

    logic              clk_sys = 1'b0;
    logic              rst_n;
    logic              ov_vsync, ov_href, ov_pclk;
    logic [DW-1:0]     ov_data;
    logic              cfg_en, cfg_clr;
    logic              pix_valid, pix_sof, pix_eol, pix_eof, stu_busy;
    logic [PW-1:0]     pix_data;
    logic [CNT_W-1:0]  stu_line_len, stu_line_cnt, stu_frame_cnt;
    logic [2:0]        stu_err;

    int total   = 0;
    int bad     = 0;
    int eol_cnt = 0;
    int eof_cnt = 0;
    logic [PW:0] exp_q [$];
    logic        exp_sof = 1'b0;

    typedef struct {
        int         lines;
        int         nbytes;
        logic [7:0] first;
        int         exp_len;
        int         exp_lcnt;
        logic [2:0] exp_err;
    } vec_t;

    vec_t vecs [4];

    ov_capture #(
        .DW(DW), .BPP(BPP), .VS_DEB(VS_DEB), .CNT_W(CNT_W), .VS_POL(1'b1)
    ) dut (
        .clk_sys(clk_sys), .rst_n(rst_n),
        .ov_vsync(ov_vsync), .ov_href(ov_href), .ov_pclk(ov_pclk), .ov_data(ov_data),
        .cfg_en(cfg_en), .cfg_clr(cfg_clr),
        .pix_valid(pix_valid), .pix_data(pix_data), .pix_sof(pix_sof),
        .pix_eol(pix_eol), .pix_eof(pix_eof),
        .stu_line_len(stu_line_len), .stu_line_cnt(stu_line_cnt),
        .stu_frame_cnt(stu_frame_cnt), .stu_err(stu_err), .stu_busy(stu_busy)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    // One clk_sys cycle; outputs are sampled on the falling edge and scored.
    task automatic tick();
        logic [PW:0] w;
        @(negedge clk_sys);
        if (pix_valid) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL pix_extra act=%0h exp=none", {pix_sof, pix_data});
            end else begin
                w = exp_q.pop_front();
                if ({pix_sof, pix_data} !== w) begin
                    bad++;
                    $display("FAIL pix act=%0h exp=%0h", {pix_sof, pix_data}, w);
                end
            end
        end
        if (pix_eol) eol_cnt++;
        if (pix_eof) eof_cnt++;
    endtask

    task automatic beat(input logic [7:0] b);
        ov_data = b;
        ov_href = 1'b1;
        ov_pclk = 1'b0;
        repeat (4) tick();
        ov_pclk = 1'b1;
        repeat (4) tick();
        ov_pclk = 1'b0;
    endtask

    task automatic send_line(input logic [7:0] first, input int n, input bit push);
        logic [PW-1:0] acc;
        logic [7:0]    b;
        acc = '0;
        for (int i = 0; i < n; i++) begin
            b   = first + 8'(i);
            acc = (acc << DW) | PW'(b);
            if (push && (((i + 1) % BPP) == 0)) begin
                exp_q.push_back({exp_sof, acc});
                exp_sof = 1'b0;
            end
            beat(b);
        end
        ov_href = 1'b0;
        repeat (8) tick();
    endtask

    task automatic frame_start();
        tick();
        ov_vsync = 1'b0;
        exp_sof  = 1'b1;
        repeat (VS_DEB + 8) tick();
    endtask

    // with_clr lands cfg_clr on the very edge where the frame end is registered.
    task automatic frame_end(input bit with_clr);
        tick();
        ov_vsync = 1'b1;
        repeat (VS_DEB + 2) tick();
        cfg_clr = with_clr;
        tick();
        cfg_clr = 1'b0;
        repeat (VS_DEB + 6) tick();
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_pix"}, 64'({pix_valid, pix_data, pix_sof, pix_eol, pix_eof}), 64'd0);
        chk({nm, "_stu"}, 64'({stu_line_len, stu_line_cnt, stu_frame_cnt, stu_err, stu_busy}), 64'd0);
    endtask

    initial begin
        int e0, f0;
        logic [7:0] lf;
        vecs[0] = '{lines: 3, nbytes: 8, first: 8'h01, exp_len: 4, exp_lcnt: 3, exp_err: 3'b000};
        vecs[1] = '{lines: 1, nbytes: 5, first: 8'h40, exp_len: 2, exp_lcnt: 1, exp_err: 3'b001};
        vecs[2] = '{lines: 2, nbytes: 2, first: 8'h80, exp_len: 1, exp_lcnt: 2, exp_err: 3'b001};
        vecs[3] = '{lines: 4, nbytes: 6, first: 8'hA0, exp_len: 3, exp_lcnt: 4, exp_err: 3'b001};

        rst_n    = 1'b0;
        ov_vsync = 1'b1;
        ov_href  = 1'b0;
        ov_pclk  = 1'b0;
        ov_data  = 8'h00;
        cfg_en   = 1'b0;
        cfg_clr  = 1'b0;
        repeat (3) tick();
        chk_all_zero("reset");
        rst_n  = 1'b1;
        cfg_en = 1'b1;
        repeat (20) tick();

        for (int r = 0; r < 4; r++) begin
            e0 = eol_cnt;
            f0 = eof_cnt;
            frame_start();
            if (r == 0) chk("busy_active", 64'(stu_busy), 64'd1);
            for (int l = 0; l < vecs[r].lines; l++) begin
                lf = vecs[r].first + 8'(l * vecs[r].nbytes);
                send_line(lf, vecs[r].nbytes, 1'b1);
            end
            frame_end(1'b0);
            chk($sformatf("line_len_r%0d", r), 64'(stu_line_len), 64'(vecs[r].exp_len));
            chk($sformatf("line_cnt_r%0d", r), 64'(stu_line_cnt), 64'(vecs[r].exp_lcnt));
            chk($sformatf("frame_cnt_r%0d", r), 64'(stu_frame_cnt), 64'(r + 1));
            chk($sformatf("err_r%0d", r), 64'(stu_err), 64'(vecs[r].exp_err));
            chk($sformatf("eol_r%0d", r), 64'(eol_cnt - e0), 64'(vecs[r].lines));
            chk($sformatf("eof_r%0d", r), 64'(eof_cnt - f0), 64'd1);
        end

        // Clear pulse.
        tick();
        cfg_clr = 1'b1;
        tick();
        cfg_clr = 1'b0;
        repeat (2) tick();
        chk("clr_err", 64'(stu_err), 64'd0);
        chk("clr_frame_cnt", 64'(stu_frame_cnt), 64'd0);

        // Vsync glitch one cycle short of the debounce length mid-frame.
        e0 = eol_cnt;
        f0 = eof_cnt;
        frame_start();
        send_line(8'h21, 4, 1'b1);
        tick();
        ov_vsync = 1'b1;
        repeat (VS_DEB - 1) tick();
        ov_vsync = 1'b0;
        repeat (VS_DEB + 4) tick();
        chk("glitch_no_eof", 64'(eof_cnt - f0), 64'd0);
        send_line(8'h31, 4, 1'b1);
        frame_end(1'b0);
        chk("glitch_eof", 64'(eof_cnt - f0), 64'd1);
        chk("glitch_eol", 64'(eol_cnt - e0), 64'd2);
        chk("glitch_line_cnt", 64'(stu_line_cnt), 64'd2);
        chk("glitch_frame_cnt", 64'(stu_frame_cnt), 64'd1);

        // cfg_en dropped mid-frame; cfg_clr coincides with that frame's end.
        f0 = eof_cnt;
        frame_start();
        send_line(8'h41, 4, 1'b1);
        cfg_en = 1'b0;
        send_line(8'h51, 4, 1'b1);
        frame_end(1'b1);
        chk("drop_eof", 64'(eof_cnt - f0), 64'd1);
        chk("drop_line_cnt", 64'(stu_line_cnt), 64'd2);
        chk("clr_at_frame_end", 64'(stu_frame_cnt), 64'd1);
        chk("drop_busy", 64'(stu_busy), 64'd0);

        // Next frame while idle: no pixels, href flagged.
        e0 = eol_cnt;
        f0 = eof_cnt;
        frame_start();
        send_line(8'h61, 4, 1'b0);
        frame_end(1'b0);
        chk("idle_eof", 64'(eof_cnt - f0), 64'd0);
        chk("idle_eol", 64'(eol_cnt - e0), 64'd0);
        chk("idle_err", 64'(stu_err), 64'd4);
        chk("idle_frame_cnt", 64'(stu_frame_cnt), 64'd1);

        // Reset mid-line, then href in WAIT_VS, then a clean frame.
        cfg_en = 1'b1;
        repeat (3) tick();
        frame_start();
        beat(8'h77);
        ov_href = 1'b1;
        rst_n   = 1'b0;
        tick();
        chk_all_zero("midline_reset");
        ov_href = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (3) tick();
        e0 = eol_cnt;
        send_line(8'h81, 4, 1'b0);
        chk("wait_vs_href_err", 64'(stu_err), 64'd4);
        chk("wait_vs_eol", 64'(eol_cnt - e0), 64'd0);
        frame_end(1'b0);
        chk("post_reset_frame_cnt0", 64'(stu_frame_cnt), 64'd0);
        frame_start();
        send_line(8'h91, 4, 1'b1);
        frame_end(1'b0);
        chk("post_reset_frame_cnt1", 64'(stu_frame_cnt), 64'd1);
        chk("post_reset_line_len", 64'(stu_line_len), 64'd2);
        chk("post_reset_line_cnt", 64'(stu_line_cnt), 64'd1);

        repeat (10) tick();
        chk("pixels_outstanding", 64'(exp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
